// File: rtl/lockstep_fault_manager.sv
// Lockstep fault manager: pairs master/shadow commit strobes within a skew window,
// compares them, and sequences rollback retries or a sticky permanent fault.
module lockstep_fault_manager #(
  parameter int DATA_WIDTH = 32,
  parameter int SKEW_MAX   = 4,
  parameter int MAX_RETRY  = 3,
  parameter int CLEAN_RUN  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] master_output,
  input  logic                  master_valid,
  input  logic [DATA_WIDTH-1:0] shadow_output,
  input  logic                  shadow_valid,
  input  logic                  rollback_ack,
  input  logic                  clear_fault,
  output logic                  match,
  output logic                  mismatch,
  output logic                  compare_done,
  output logic                  rollback_req,
  output logic                  core_hold,
  output logic                  fault,
  output logic [3:0]            retry_count,
  output logic [CNT_WIDTH-1:0]  error_count
);

  typedef enum logic [2:0] {RUN, WAIT_SHADOW, WAIT_MASTER, RECOVER, FAULT} state_t;

  localparam logic [3:0] SKEW_LAST  = 4'(SKEW_MAX - 1);
  localparam logic [3:0] MAX_R      = 4'(MAX_RETRY);
  localparam logic [7:0] CLEAN_LAST = 8'(CLEAN_RUN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] held;
  logic [3:0]            timer;
  logic [7:0]            clean_cnt;
  logic                  ev, eq;

  // Compare event: a paired commit, a same-side repeat (desync) or a skew timeout.
  always_comb begin
    ev = 1'b0;
    eq = 1'b0;
    case (state)
      RUN: if (master_valid && shadow_valid) begin
        ev = 1'b1;
        eq = (master_output == shadow_output);
      end
      WAIT_SHADOW: if (shadow_valid) begin
        ev = 1'b1;
        eq = (held == shadow_output);
      end else if (master_valid || timer == SKEW_LAST) begin
        ev = 1'b1;
      end
      WAIT_MASTER: if (master_valid) begin
        ev = 1'b1;
        eq = (held == master_output);
      end else if (shadow_valid || timer == SKEW_LAST) begin
        ev = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (ev) begin
      if (eq)                       state_n = RUN;
      else if (retry_count < MAX_R) state_n = RECOVER;
      else                          state_n = FAULT;
    end else begin
      case (state)
        RUN: begin
          if (master_valid && !shadow_valid)      state_n = WAIT_SHADOW;
          else if (shadow_valid && !master_valid) state_n = WAIT_MASTER;
        end
        RECOVER: if (rollback_ack) state_n = RUN;
        FAULT:   if (clear_fault)  state_n = RUN;
        default: ;
      endcase
    end
  end

  always_comb begin
    rollback_req = (state == RECOVER);
    core_hold    = (state == RECOVER) || (state == FAULT);
    fault        = (state == FAULT);
  end

  // Timer is zero on entry to a wait state since waits are only entered from RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held  <= '0;
      timer <= '0;
    end else begin
      if (state == RUN && (master_valid ^ shadow_valid))
        held <= master_valid ? master_output : shadow_output;
      timer <= (state == WAIT_SHADOW || state == WAIT_MASTER) ? timer + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match        <= 1'b1;
      mismatch     <= 1'b0;
      compare_done <= 1'b0;
      retry_count  <= '0;
      error_count  <= '0;
      clean_cnt    <= '0;
    end else begin
      compare_done <= ev;
      if (ev && eq) begin
        match    <= 1'b1;
        mismatch <= 1'b0;
        if (clean_cnt == CLEAN_LAST) begin
          clean_cnt   <= '0;
          retry_count <= '0;
        end else begin
          clean_cnt <= clean_cnt + 8'd1;
        end
      end else if (ev) begin
        match     <= 1'b0;
        mismatch  <= 1'b1;
        clean_cnt <= '0;
        if (!(&error_count))        error_count <= error_count + CNT_ONE;
        if (retry_count < MAX_R)    retry_count <= retry_count + 4'd1;
      end else if (state == FAULT && clear_fault) begin
        match       <= 1'b1;
        mismatch    <= 1'b0;
        retry_count <= '0;
      end
    end
  end

endmodule
